text_line_writer: RTL

TEXT_LINE_WRITER -- requirements
Module: text_line_writer

---
 rtl/text_line_writer_pkg.sv | 29 ++
 rtl/text_line_writer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/text_line_writer_pkg.sv
// Shared constants, state encoding and character pick for text_line_writer.
// Keeps line geometry and the blank glyph in one place.
package text_line_writer_pkg;

  localparam int         LINE_LEN = 32;
  localparam int         COL_W    = 5;
  localparam int         TEXT_W   = LINE_LEN * 8;
  localparam logic [7:0] BLANK    = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LINE  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Column 0 sits in the top byte; NUL renders as a blank.
  function automatic logic [7:0] pick_char(
    input logic [TEXT_W-1:0] line,
    input logic [COL_W-1:0]  col
  );
    logic [7:0] b;
    int         idx;
    idx = (LINE_LEN - 1) - int'(col);
    b   = line[idx*8 +: 8];
    return (b == 8'h00) ? BLANK : b;
  endfunction

endpackage

// File: rtl/text_line_writer.sv
// Streams a 32-character text line, or a full-screen blank,
// into a character RAM one byte per clock.
import text_line_writer_pkg::*;

module text_line_writer #(
  parameter int ROW_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [TEXT_W-1:0]    text,
  input  logic [ROW_WIDTH-1:0] row,
  input  logic                 valid,
  input  logic                 clear,
  output logic                 ready,
  output logic [ROW_WIDTH+4:0] charAddress,
  output logic [7:0]           charData,
  output logic                 charWrite,
  output logic                 done
);

  localparam int AW = ROW_WIDTH + COL_W;

  state_t               r_state, w_next_state;
  logic [COL_W-1:0]     r_col, w_next_col;
  logic [AW-1:0]        r_addr, w_next_addr;
  logic [TEXT_W-1:0]    r_text, w_next_text;
  logic [ROW_WIDTH-1:0] r_row, w_next_row;

  logic                 r_ready, w_ready;
  logic [AW-1:0]        r_char_addr, w_char_addr;
  logic [7:0]           r_char_data, w_char_data;
  logic                 r_char_write, w_char_write;
  logic                 r_done, w_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_addr       <= '0;
      r_text       <= '0;
      r_row        <= '0;
      r_ready      <= 1'b1;
      r_char_addr  <= '0;
      r_char_data  <= '0;
      r_char_write <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_col        <= w_next_col;
      r_addr       <= w_next_addr;
      r_text       <= w_next_text;
      r_row        <= w_next_row;
      r_ready      <= w_ready;
      r_char_addr  <= w_char_addr;
      r_char_data  <= w_char_data;
      r_char_write <= w_char_write;
      r_done       <= w_done;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_col   = r_col;
    w_next_addr  = r_addr;
    w_next_text  = r_text;
    w_next_row   = r_row;
    unique case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_next_state = S_CLEAR;
          w_next_addr  = '0;
        end else if (valid) begin
          w_next_state = S_LINE;
          w_next_col   = '0;
          w_next_text  = text;
          w_next_row   = row;
        end
      end
      S_LINE: begin
        if (r_col == COL_W'(LINE_LEN - 1)) begin
          w_next_state = S_DONE;
          w_next_col   = '0;
        end else begin
          w_next_col = r_col + 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_addr == '1) begin
          w_next_state = S_DONE;
          w_next_addr  = '0;
        end else begin
          w_next_addr = r_addr + 1'b1;
        end
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers
  // present each write in the cycle right after it is scheduled.
  always_comb begin
    w_ready      = (w_next_state == S_IDLE);
    w_char_write = 1'b0;
    w_done       = 1'b0;
    w_char_addr  = '0;
    w_char_data  = '0;
    unique case (w_next_state)
      S_LINE: begin
        w_char_write = 1'b1;
        w_char_addr  = {w_next_row, w_next_col};
        w_char_data  = pick_char(w_next_text, w_next_col);
      end
      S_CLEAR: begin
        w_char_write = 1'b1;
        w_char_addr  = w_next_addr;
        w_char_data  = BLANK;
      end
      S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  assign ready       = r_ready;
  assign charAddress = r_char_addr;
  assign charData    = r_char_data;
  assign charWrite   = r_char_write;
  assign done        = r_done;

endmodule
